mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage of the 5-stage MIPS core, directly downstream of the execute stage.
- Registers ex_to_mem_bus and waits on the data-SRAM read response for loads, which may have variable latency. Raises a stall request while the data is outstanding.
- Extracts and extends LB/LBU/LH/LHU/LW data, selects the ALU result or the load data, and drives mem_to_wb_bus plus the MEM forwarding outputs to ID.

Parameters:
- EX_TO_MEM_WD, 79, ex_to_mem_bus width.
- MEM_TO_WB_WD, 70, mem_to_wb_bus width.
- STALL_BUS, 6, stall vector width. Index map: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.

Ports:
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- stall  in  STALL_BUS  stall vector (Stop=1, NoStop=0)
- ex_to_mem_bus  in  79  fields, msb first:
  - ld_op[78:76]
  - ex_pc[75:44]
  - data_ram_en[43]
  - data_ram_wen[42:39]
  - sel_rf_res[38]
  - rf_we[37]
  - rf_waddr[36:32]
  - ex_result[31:0]
- data_sram_rdata  in  32  read data, valid only when data_sram_rvalid=1
- data_sram_rvalid  in  1  one-cycle pulse per read request
- mem_to_wb_bus  out  70  fields: mem_pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]
- stallreq_mem  out  1  load in MEM whose data is not yet available
- mem_wreg  out  1  forwarding: rf_we of the MEM instruction
- mem_waddr  out  5  forwarding: rf_waddr
- mem_wdata  out  32  forwarding: final writeback value; meaningful only when stallreq_mem=0

Behaviour:
- Pipeline register r, updated in priority order:
  - rst: r <= 0.
  - else stall[3]==Stop && stall[4]==NoStop: r <= 0 (bubble).
  - else stall[3]==NoStop: r <= ex_to_mem_bus.
  - else hold.
- An all-zero r is a NOP: rf_we=0, no load.
- is_load = data_ram_en && data_ram_wen==0 && sel_rf_res, evaluated on the registered fields.
- Stores need no MEM action; the write was issued by EX.
- FSM, state register reset to IDLE:
  - IDLE: no outstanding load.
  - WAIT: load in MEM, data not yet received.
  - GOT: data captured in rdata_hold, instruction not yet advanced.
- Whenever r loads a new instruction (or bubble): next state = WAIT if the incoming instruction is a load, else IDLE. This overrides all other transitions.
- In WAIT with data_sram_rvalid=1 and r not loading: rdata_hold <= data_sram_rdata, go to GOT.
- In WAIT with data_sram_rvalid=1 and r loading the same cycle: rdata is consumed combinationally and nothing is captured.
- data_sram_rvalid in IDLE or GOT is ignored. This includes a late response after reset.
- stallreq_mem = (state==WAIT) && !data_sram_rvalid. The output is combinational with zero-cycle latency, so a response arriving in the first MEM cycle causes no stall.
- raw = (state==GOT) ? rdata_hold : data_sram_rdata.
- Lane select uses off = ex_result[1:0], little-endian.
- ld_op encoding:
  - 000 / 101: LW, full word.
  - 001: LB, byte raw[8*off+7 : 8*off], sign-extended.
  - 010: LBU, same byte, zero-extended.
  - 011: LH, halfword raw[16*off[1]+15 : 16*off[1]], sign-extended.
  - 100: LHU, same halfword, zero-extended.
  - 110 / 111: treated as LW.
- Misalignment is not checked here; off[0] is ignored for halfwords.
- rf_wdata = sel_rf_res ? load_data : ex_result.
- mem_to_wb_bus = {ex_pc, rf_we, rf_waddr, rf_wdata}.
- mem_wreg, mem_waddr and mem_wdata mirror the corresponding mem_to_wb_bus fields.
- Reset values: mem_to_wb_bus, mem_wreg, mem_waddr and mem_wdata are all 0; stallreq_mem=0.
- Reset mid-WAIT: the state returns to IDLE the following cycle and the outstanding load is discarded.
- Downstream stall (stall[4]==Stop) with data in hand: GOT holds rdata_hold stable for any number of cycles.

Decomposition:
- Add to lib/defines.vh:
  - EX_TO_MEM_WD=79, MEM_TO_WB_WD=70.
  - LD_LW/LB/LBU/LH/LHU codes.
  - MEM FSM state codes.
- One sub-module: load_ext, purely combinational (raw, off, ld_op -> load_data), unit-testable on its own.

Test Plan:
- LW to $5, addr 0x100, rvalid=1 in the first MEM cycle, rdata=0x8899AABB:
  - stallreq_mem stays 0.
  - mem_to_wb_bus carries rf_waddr=5, rf_wdata=0x8899AABB.
- LB, addr offset 2, rdata=0x12F45678, rvalid after 3 cycles:
  - stallreq_mem=1 for exactly 3 cycles.
  - rf_wdata=0xFFFFFFF4; LBU gives 0x000000F4.
- LHU offset 2 with rdata=0x80017FFF gives 0x00008001; LH offset 0 gives 0x00007FFF.
- rvalid arrives while stall[4]=Stop for 2 cycles, then the bus changes to 0xDEADBEEF:
  - State goes to GOT.
  - rf_wdata keeps the captured value until r advances.
- stall[3]=Stop with stall[4]=NoStop: the next cycle shows an all-zero bus (mem_wreg=0). An ADD result 0x7 with sel_rf_res=0 passes ex_result straight through.
- rst asserted in WAIT, then rvalid pulses: state is IDLE, stallreq_mem=0 and outputs stay 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: bus layout,
// load-op codes and the load-wait FSM states.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int STALL_BUS    = 6;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_GOT  = 2'b10
  } mem_state_e;

  typedef struct packed {
    logic [2:0]  ld_op;
    logic [31:0] ex_pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  function automatic logic is_load(input ex_to_mem_t b);
    return b.data_ram_en && (b.data_ram_wen == 4'b0000) && b.sel_rf_res;
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extraction: picks the addressed byte/halfword out of the read
// word (little-endian) and sign- or zero-extends it.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_ld_op,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by extension; off[0] is ignored for halfwords.
  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'b00:   w_byte = i_raw[7:0];
      2'b01:   w_byte = i_raw[15:8];
      2'b10:   w_byte = i_raw[23:16];
      2'b11:   w_byte = i_raw[31:24];
      default: w_byte = i_raw[7:0];
    endcase
    if (i_off[1]) begin
      w_half = i_raw[31:16];
    end else begin
      w_half = i_raw[15:0];
    end
    case (i_ld_op)
      LD_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_load_data = {24'h000000, w_byte};
      LD_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_load_data = {16'h0000, w_half};
      default: o_load_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: holds the EX/MEM register, tracks the
// outstanding data-SRAM read and produces the writeback bus and ID forwarding.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    stallreq_mem,
  output logic                    mem_wreg,
  output logic [4:0]              mem_waddr,
  output logic [31:0]             mem_wdata
);

  ex_to_mem_t  w_in;
  ex_to_mem_t  w_next;
  ex_to_mem_t  r_bus;
  mem_state_e  r_state;
  logic [31:0] r_rdata_hold;
  logic [31:0] w_raw;
  logic [31:0] w_load_data;
  logic [31:0] w_wdata;
  logic        w_advance;
  logic        w_unused_stall;

  assign w_in           = ex_to_mem_bus;
  assign w_unused_stall = ^{stall[5], stall[2:0]};

  // r only holds when both EX/MEM and MEM/WB are stopped; a stopped EX/MEM
  // with a free MEM/WB inserts a bubble.
  assign w_advance = !(stall[3] && stall[4]);
  assign w_next    = stall[3] ? '0 : w_in;

  // Pipeline register and load-wait FSM; a new instruction overrides any
  // pending response tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus        <= '0;
      r_state      <= ST_IDLE;
      r_rdata_hold <= 32'h0000_0000;
    end else if (w_advance) begin
      r_bus   <= w_next;
      r_state <= is_load(w_next) ? ST_WAIT : ST_IDLE;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (data_sram_rvalid) begin
            r_rdata_hold <= data_sram_rdata;
            r_state      <= ST_GOT;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Zero-latency stall request so a same-cycle response never stalls.
  assign stallreq_mem = (r_state == ST_WAIT) && !data_sram_rvalid;
  assign w_raw        = (r_state == ST_GOT) ? r_rdata_hold : data_sram_rdata;

  mem_stage_load_ext u_load_ext (
    .i_raw       (w_raw),
    .i_off       (r_bus.ex_result[1:0]),
    .i_ld_op     (r_bus.ld_op),
    .o_load_data (w_load_data)
  );

  assign w_wdata       = r_bus.sel_rf_res ? w_load_data : r_bus.ex_result;
  assign mem_to_wb_bus = {r_bus.ex_pc, r_bus.rf_we, r_bus.rf_waddr, w_wdata};
  assign mem_wreg      = r_bus.rf_we;
  assign mem_waddr     = r_bus.rf_waddr;
  assign mem_wdata     = w_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writeback buses are queued as each
// instruction is issued and popped when the stage presents its result.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [78:0] ex_bus;
  logic [31:0] rdata;
  logic        rvalid;
  logic [69:0] mem_to_wb_bus;
  logic        stallreq_mem;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [69:0] sb[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_to_mem_bus    (ex_bus),
    .data_sram_rdata  (rdata),
    .data_sram_rvalid (rvalid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .stallreq_mem     (stallreq_mem),
    .mem_wreg         (mem_wreg),
    .mem_waddr        (mem_waddr),
    .mem_wdata        (mem_wdata)
  );

  task automatic chk(input string tag, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [78:0] mk(input logic [2:0] op, input logic [31:0] pc,
                                     input logic en, input logic [3:0] wen, input logic sel,
                                     input logic we, input logic [4:0] wa, input logic [31:0] res);
    return {op, pc, en, wen, sel, we, wa, res};
  endfunction

  // Issue one instruction, hold it in MEM, answer its read after lat cycles,
  // optionally keep MEM/WB stopped for got_hold cycles, then drain.
  task automatic do_instr(input string tag, input logic [78:0] bus, input logic [31:0] rd,
                          input int lat, input int got_hold, input logic [31:0] exp_wdata);
    logic ld;
    int stalls;
    logic [69:0] e;
    ld = bus[43] && (bus[42:39] == 4'b0000) && bus[38];
    sb.push_back({bus[75:44], bus[37], bus[36:32], exp_wdata});
    @(negedge clk);
    ex_bus = bus; stall = 6'b000000; rvalid = 1'b0; rdata = 32'h0;
    @(negedge clk);
    ex_bus = '0; stall = 6'b011111;
    stalls = 0;
    if (ld) begin
      for (int i = 0; i < lat; i++) begin
        #1;
        if (stallreq_mem) stalls++;
        @(negedge clk);
      end
      rvalid = 1'b1; rdata = rd;
    end
    #1;
    chk({tag, "_stallcnt"}, 70'(stalls), 70'(ld ? lat : 0));
    chk({tag, "_nostall"}, {69'd0, stallreq_mem}, 70'd0);
    e = sb.pop_front();
    chk({tag, "_bus"}, mem_to_wb_bus, e);
    chk({tag, "_fwd"}, {32'd0, mem_wreg, mem_waddr, mem_wdata}, {32'd0, e[37:0]});
    if (got_hold > 0) begin
      @(negedge clk);
      rvalid = 1'b0; rdata = 32'hDEADBEEF;
      for (int i = 0; i < got_hold; i++) begin
        #1;
        chk({tag, "_state_got"}, {68'd0, dut.r_state}, {68'd0, ST_GOT});
        chk({tag, "_hold_bus"}, mem_to_wb_bus, e);
        @(negedge clk);
      end
    end
    stall = 6'b000000; ex_bus = '0;
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'h0;
    #1;
    chk({tag, "_drain"}, mem_to_wb_bus, 70'd0);
  endtask

  initial begin
    logic [78:0] add_i;
    rst = 1'b1; stall = 6'b000000; ex_bus = '0; rdata = 32'h0; rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_bus", mem_to_wb_bus, 70'd0);
    chk("reset_stallreq", {69'd0, stallreq_mem}, 70'd0);
    chk("reset_fwd", {32'd0, mem_wreg, mem_waddr, mem_wdata}, 70'd0);

    do_instr("lw_fast", mk(3'b000, 32'h0000_1000, 1'b1, 4'h0, 1'b1, 1'b1, 5'd5, 32'h100),
             32'h8899AABB, 0, 0, 32'h8899AABB);
    do_instr("lb_off2", mk(3'b001, 32'h0000_1004, 1'b1, 4'h0, 1'b1, 1'b1, 5'd6, 32'h102),
             32'h12F45678, 3, 0, 32'hFFFFFFF4);
    do_instr("lbu_off2", mk(3'b010, 32'h0000_1008, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h102),
             32'h12F45678, 1, 0, 32'h000000F4);
    do_instr("lb_off3", mk(3'b001, 32'h0000_100C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h103),
             32'h12F45678, 1, 0, 32'h00000012);
    do_instr("lhu_off2", mk(3'b100, 32'h0000_1010, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h102),
             32'h80017FFF, 2, 0, 32'h00008001);
    do_instr("lh_off0", mk(3'b011, 32'h0000_1014, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h100),
             32'h80017FFF, 0, 0, 32'h00007FFF);
    do_instr("lh_off2", mk(3'b011, 32'h0000_1018, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h102),
             32'h80017FFF, 1, 0, 32'hFFFF8001);
    do_instr("lw_op110", mk(3'b110, 32'h0000_101C, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h201),
             32'hCAFEF00D, 1, 0, 32'hCAFEF00D);
    do_instr("lw_got", mk(3'b000, 32'h0000_1020, 1'b1, 4'h0, 1'b1, 1'b1, 5'd13, 32'h204),
             32'h0BADF00D, 1, 2, 32'h0BADF00D);
    do_instr("store", mk(3'b000, 32'h0000_1024, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h300),
             32'h0, 0, 0, 32'h00000300);
    do_instr("add", mk(3'b000, 32'h0000_1028, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h7),
             32'h0, 0, 0, 32'h00000007);

    // Bubble: EX/MEM stopped while MEM/WB runs.
    add_i = mk(3'b000, 32'h0000_102C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h7);
    sb.push_back({32'h0000_102C, 1'b1, 5'd4, 32'h7});
    @(negedge clk);
    ex_bus = add_i; stall = 6'b000000;
    @(negedge clk);
    stall = 6'b001111;
    #1;
    chk("bubble_pre", mem_to_wb_bus, sb.pop_front());
    @(negedge clk);
    #1;
    chk("bubble_bus", mem_to_wb_bus, 70'd0);
    chk("bubble_wreg", {69'd0, mem_wreg}, 70'd0);
    stall = 6'b000000; ex_bus = '0;

    // Reset while a load is outstanding, then a late response.
    @(negedge clk);
    ex_bus = mk(3'b000, 32'h0000_1030, 1'b1, 4'h0, 1'b1, 1'b1, 5'd14, 32'h208);
    @(negedge clk);
    ex_bus = '0; stall = 6'b011111;
    #1;
    chk("rst_wait_stallreq", {69'd0, stallreq_mem}, 70'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h55AA55AA;
    #1;
    chk("rst_state_idle", {68'd0, dut.r_state}, {68'd0, ST_IDLE});
    chk("rst_stallreq", {69'd0, stallreq_mem}, 70'd0);
    chk("rst_bus", mem_to_wb_bus, 70'd0);
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'h0;
    #1;
    chk("rst_late_state", {68'd0, dut.r_state}, {68'd0, ST_IDLE});
    chk("rst_late_bus", {32'd0, mem_wreg, mem_waddr, mem_wdata}, 70'd0);
    stall = 6'b000000;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
